getir_tamponu_p: RTL and testbench
==================================

Name: getir_tamponu_p

Overview:
Parametrised fetch front-end buffer that replaces the single-entry stall buffer of the fetch stage. It owns the program counter and issues pipelined requests to the instruction cache with several requests in flight. Responses go into a DERINLIK-entry instruction queue, and one registered {ps, buyruk} pair is handed to the decode (coz) stage. Redirects flush the queue and discard stale in-flight responses; the two redirect sources are prioritised.

Parameters:
DERINLIK, 4, instruction queue entries (power of two, >=2)
BEKLEYEN_MAX, 2, max outstanding cache requests (>=1)
PS_BIT, 32, program-counter width
BUYRUK_BIT, 32, instruction width
SIFIRLAMA_PS, 32'h0000_0000, PC after reset
NOP_BUYRUK, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
durdur_i  in  1  decode stall; hold outputs
istek_gecerli_o  out  1  cache request valid
istek_hazir_i  in  1  cache accepts request this cycle
istek_adres_o  out  PS_BIT  request address
yanit_gecerli_i  in  1  in-order cache response valid
yanit_buyruk_i  in  BUYRUK_BIT  response instruction
hata_gecerli_i  in  1  branch mispredict / jal redirect (priority 1)
hata_adres_i  in  PS_BIT  redirect target
ongoru_gecerli_i  in  1  predictor taken redirect (priority 2)
ongoru_adres_i  in  PS_BIT  predicted target
ps_o  out  PS_BIT  PC of instruction to decode
buyruk_o  out  BUYRUK_BIT  instruction to decode
gecerli_o  out  1  ps_o/buyruk_o valid
doluluk_o  out  $clog2(DERINLIK)+1  queue occupancy (debug)

Behaviour:
- Reset (rst_i=0, asynchronous): ps_r=SIFIRLAMA_PS, queue empty, bekleyen=0, atilacak=0, gecerli_o=0, buyruk_o=NOP_BUYRUK, ps_o=0, istek_gecerli_o=0, doluluk_o=0. Reset mid-operation drops everything; responses arriving after reset release are not expected.
- Redirect: yonlendir = hata_gecerli_i | ongoru_gecerli_i. Target = hata_adres_i if hata_gecerli_i, else ongoru_adres_i. Both redirects in the same cycle: hata wins.
- Request:
  - istek_gecerli_o = !yonlendir && (doluluk + bekleyen < DERINLIK) && (bekleyen < BEKLEYEN_MAX).
  - istek_adres_o = ps_r.
  - Handshake completes when istek_gecerli_o && istek_hazir_i; then ps_r += 4 (wraps modulo 2^PS_BIT) and bekleyen increments.
  - Issue is credit-based, so a push never overflows the queue.
- Response:
  - Each yanit_gecerli_i decrements bekleyen. A request and a response in the same cycle leave bekleyen unchanged.
  - If atilacak>0 or yonlendir is high, the response is dropped and atilacak decrements (floor 0). Otherwise the response is pushed with the PC copy of its request; a PS FIFO of depth BEKLEYEN_MAX tracks PCs in flight.
- Redirect cycle:
  - ps_r <= target; queue cleared; in-flight PC FIFO cleared.
  - atilacak <= bekleyen_r - (yanit_gecerli_i ? 1 : 0).
  - gecerli_o <= 0 and buyruk_o <= NOP_BUYRUK, regardless of durdur_i.
  - Requests resume the next cycle.
- Output stage (no redirect):
  - durdur_i=1: ps_o/buyruk_o/gecerli_o hold.
  - durdur_i=0 and queue non-empty: pop head into ps_o/buyruk_o, gecerli_o=1.
  - durdur_i=0 and queue empty: gecerli_o=0, buyruk_o=NOP_BUYRUK, ps_o holds.
  - Push and pop in the same cycle are allowed, including when the queue is full or empty.
  - A response into an empty queue is visible at the output at the earliest on the next edge: 1-cycle latency from the queue.
- Pointers: read/write pointers of $clog2(DERINLIK) bits plus a wrap bit. Full = addresses equal and wrap bits differ; empty = pointers equal.
- Invariants: atilacak <= bekleyen <= BEKLEYEN_MAX; doluluk + bekleyen <= DERINLIK.

Test Plan:
- Reset → release with istek_hazir_i=1 and 1-cycle responses → addresses 0,4,8…; buyruk_o follows in order with gecerli_o=1; NOP_BUYRUK/gecerli_o=0 before the first push.
- durdur_i=1 for 10 cycles with streaming responses → doluluk_o reaches 4 and holds; istek_gecerli_o drops; outputs unchanged; after release, 4 consecutive instructions with no loss or duplication.
- Two requests outstanding (0x10, 0x14), hata_gecerli_i with hata_adres_i=0x200 → both later responses dropped; next delivered ps_o=0x200.
- hata_gecerli_i (0x300) and ongoru_gecerli_i (0x400) in the same cycle → next request address 0x300.
- Redirect in the same cycle as a response while bekleyen=2 → atilacak=1; exactly one further response dropped; the following response is tagged with the new target.
- DERINLIK=2, BEKLEYEN_MAX=1: long stream with random durdur_i → pointer wrap is correct; invariants hold every cycle (assertions).

Source files
------------

// File: rtl/getir_tamponu_p_if.sv
// Fetch <-> instruction cache bus: pipelined request channel plus
// in-order response channel. master = fetch buffer, slave = cache.
interface getir_tamponu_p_if #(
  parameter int PS_BIT     = 32,
  parameter int BUYRUK_BIT = 32
);
  logic                  istek_gecerli;
  logic                  istek_hazir;
  logic [PS_BIT-1:0]     istek_adres;
  logic                  yanit_gecerli;
  logic [BUYRUK_BIT-1:0] yanit_buyruk;

  modport master (
    output istek_gecerli, istek_adres,
    input  istek_hazir, yanit_gecerli, yanit_buyruk
  );

  modport slave (
    input  istek_gecerli, istek_adres,
    output istek_hazir, yanit_gecerli, yanit_buyruk
  );
endinterface

// File: rtl/getir_tamponu_p.sv
// Fetch front-end buffer: owns the PC, keeps up to BEKLEYEN_MAX cache
// requests in flight, queues responses in a DERINLIK-entry instruction
// queue and hands one registered {ps, buyruk} pair to decode. Redirects
// flush everything and discard responses of requests already in flight.
module getir_tamponu_p #(
  parameter int                    DERINLIK     = 4,
  parameter int                    BEKLEYEN_MAX = 2,
  parameter int                    PS_BIT       = 32,
  parameter int                    BUYRUK_BIT   = 32,
  parameter logic [PS_BIT-1:0]     SIFIRLAMA_PS = '0,
  parameter logic [BUYRUK_BIT-1:0] NOP_BUYRUK   = BUYRUK_BIT'(32'h0000_0013)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    durdur_i,
  getir_tamponu_p_if.master       bus,
  input  logic                    hata_gecerli_i,
  input  logic [PS_BIT-1:0]       hata_adres_i,
  input  logic                    ongoru_gecerli_i,
  input  logic [PS_BIT-1:0]       ongoru_adres_i,
  output logic [PS_BIT-1:0]       ps_o,
  output logic [BUYRUK_BIT-1:0]   buyruk_o,
  output logic                    gecerli_o,
  output logic [$clog2(DERINLIK):0] doluluk_o
);
  localparam int AW = $clog2(DERINLIK);
  localparam int PW = (BEKLEYEN_MAX > 1) ? $clog2(BEKLEYEN_MAX) : 1;
  localparam int BW = $clog2(BEKLEYEN_MAX + 1);

  logic [PS_BIT-1:0]     r_ps;
  logic [BW-1:0]         r_bekleyen;
  logic [BW-1:0]         r_atilacak;
  logic [AW:0]           r_yaz, r_oku;
  logic [PS_BIT-1:0]     r_kuy_ps  [DERINLIK];
  logic [BUYRUK_BIT-1:0] r_kuy_buy [DERINLIK];
  logic [PS_BIT-1:0]     r_ucus_ps [BEKLEYEN_MAX];
  logic [PW-1:0]         r_ucus_yaz, r_ucus_oku;

  logic              w_yon, w_yanit, w_at, w_it, w_cek, w_atesle;
  logic              w_bos, w_yer_var, w_kredi, w_istek;
  logic [PS_BIT-1:0] w_hedef;
  logic [AW:0]       w_doluluk;

  // in-flight PC ring index; depth need not be a power of two
  function automatic logic [PW-1:0] sonraki(input logic [PW-1:0] i);
    return (int'(i) == BEKLEYEN_MAX - 1) ? '0 : i + PW'(1);
  endfunction

  // mispredict outranks the predictor
  assign w_yon   = hata_gecerli_i | ongoru_gecerli_i;
  assign w_hedef = hata_gecerli_i ? hata_adres_i : ongoru_adres_i;

  assign w_doluluk = r_yaz - r_oku;
  assign w_bos     = (r_yaz == r_oku);
  assign doluluk_o = w_doluluk;

  // credit check: every outstanding request already owns a queue slot
  assign w_yer_var = (int'(w_doluluk) + int'(r_bekleyen)) < DERINLIK;
  assign w_kredi   = int'(r_bekleyen) < BEKLEYEN_MAX;
  assign w_istek   = rst_i & ~w_yon & w_yer_var & w_kredi;
  assign w_atesle  = w_istek & bus.istek_hazir;

  assign bus.istek_gecerli = w_istek;
  assign bus.istek_adres   = r_ps;

  // stale responses (pending discard or arriving during redirect) are dropped
  assign w_yanit = bus.yanit_gecerli;
  assign w_at    = w_yanit & (w_yon | (r_atilacak != '0));
  assign w_it    = w_yanit & ~w_at;
  assign w_cek   = ~w_yon & ~durdur_i & ~w_bos;

  // PC, pointers, outstanding and discard counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ps       <= SIFIRLAMA_PS;
      r_bekleyen <= '0;
      r_atilacak <= '0;
      r_yaz      <= '0;
      r_oku      <= '0;
      r_ucus_yaz <= '0;
      r_ucus_oku <= '0;
    end else begin
      if (w_yon) begin
        r_ps       <= w_hedef;
        r_yaz      <= '0;
        r_oku      <= '0;
        r_ucus_yaz <= '0;
        r_ucus_oku <= '0;
        r_atilacak <= r_bekleyen - BW'(w_yanit);
      end else begin
        if (w_atesle) begin
          r_ps       <= r_ps + PS_BIT'(4);
          r_ucus_yaz <= sonraki(r_ucus_yaz);
        end
        if (w_it) begin
          r_yaz      <= r_yaz + (AW+1)'(1);
          r_ucus_oku <= sonraki(r_ucus_oku);
        end
        if (w_cek) r_oku <= r_oku + (AW+1)'(1);
        if (w_yanit && r_atilacak != '0) r_atilacak <= r_atilacak - BW'(1);
      end
      r_bekleyen <= r_bekleyen + BW'(w_atesle) - BW'(w_yanit);
    end
  end

  // storage: in-flight PC copies and the instruction queue
  always_ff @(posedge clk_i) begin
    if (w_atesle) r_ucus_ps[r_ucus_yaz] <= r_ps;
    if (w_it) begin
      r_kuy_ps[r_yaz[AW-1:0]]  <= r_ucus_ps[r_ucus_oku];
      r_kuy_buy[r_yaz[AW-1:0]] <= bus.yanit_buyruk;
    end
  end

  // decode-facing register: bubble on redirect, hold on stall, else pop
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ps_o      <= '0;
      buyruk_o  <= NOP_BUYRUK;
      gecerli_o <= 1'b0;
    end else if (w_yon) begin
      buyruk_o  <= NOP_BUYRUK;
      gecerli_o <= 1'b0;
    end else if (!durdur_i) begin
      if (!w_bos) begin
        ps_o      <= r_kuy_ps[r_oku[AW-1:0]];
        buyruk_o  <= r_kuy_buy[r_oku[AW-1:0]];
        gecerli_o <= 1'b1;
      end else begin
        buyruk_o  <= NOP_BUYRUK;
        gecerli_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_getir_tamponu_p.sv
// Bench for getir_tamponu_p: two instances (4/2 and 2/1), each fed by a
// random-latency in-order cache and checked every cycle against a
// queue-based reference model.
module tb_getir_tamponu_p;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       durdur, hata, ong, hazir, yv, ig, go;
  logic [1:0][31:0] hadr, oadr, yb, iadr, pso, buyo;
  logic [2:0]       dol0;
  logic [1:0]       dol1;

  getir_tamponu_p_if bus0();
  getir_tamponu_p_if bus1();

  assign bus0.istek_hazir   = hazir[0];
  assign bus0.yanit_gecerli = yv[0];
  assign bus0.yanit_buyruk  = yb[0];
  assign ig[0]              = bus0.istek_gecerli;
  assign iadr[0]            = bus0.istek_adres;
  assign bus1.istek_hazir   = hazir[1];
  assign bus1.yanit_gecerli = yv[1];
  assign bus1.yanit_buyruk  = yb[1];
  assign ig[1]              = bus1.istek_gecerli;
  assign iadr[1]            = bus1.istek_adres;

  getir_tamponu_p #(.DERINLIK(4), .BEKLEYEN_MAX(2)) u0 (
    .clk_i(clk), .rst_i(rst_n), .durdur_i(durdur[0]), .bus(bus0),
    .hata_gecerli_i(hata[0]), .hata_adres_i(hadr[0]),
    .ongoru_gecerli_i(ong[0]), .ongoru_adres_i(oadr[0]),
    .ps_o(pso[0]), .buyruk_o(buyo[0]), .gecerli_o(go[0]), .doluluk_o(dol0));

  getir_tamponu_p #(.DERINLIK(2), .BEKLEYEN_MAX(1)) u1 (
    .clk_i(clk), .rst_i(rst_n), .durdur_i(durdur[1]), .bus(bus1),
    .hata_gecerli_i(hata[1]), .hata_adres_i(hadr[1]),
    .ongoru_gecerli_i(ong[1]), .ongoru_adres_i(oadr[1]),
    .ps_o(pso[1]), .buyruk_o(buyo[1]), .gecerli_o(go[1]), .doluluk_o(dol1));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int c_lmin = 1;
  int c_lmax = 1;
  int D [2];
  int BM [2];

  // reference model state
  logic [31:0] m_ps [2];
  int          m_bek [2];
  int          m_drop [2];
  logic [31:0] m_tag [2][$];
  logic [63:0] m_q [2][$];
  logic [31:0] m_ops [2];
  logic [31:0] m_obuy [2];
  logic        m_og [2];
  // cache model
  logic [31:0] c_adr [2][$];
  int          c_due [2][$];

  function automatic logic [31:0] ozet(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic denetle(input string etiket, input logic [63:0] gozlenen,
                         input logic [63:0] beklenen);
    n_chk++;
    if (gozlenen !== beklenen) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", etiket, cyc, gozlenen, beklenen);
    end
  endtask

  // one clock: present responses, check at negedge, advance models
  task automatic cevrim();
    logic        yon, ereq, fire;
    logic [31:0] tgt, tag;
    logic [63:0] c;
    int          bek0;
    for (int k = 0; k < 2; k++) begin
      if (c_adr[k].size() > 0 && c_due[k][0] <= cyc) begin
        yv[k] = 1'b1; yb[k] = ozet(c_adr[k][0]);
      end else begin
        yv[k] = 1'b0; yb[k] = $urandom;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      yon  = hata[k] | ong[k];
      tgt  = hata[k] ? hadr[k] : oadr[k];
      ereq = !yon && (m_q[k].size() + m_bek[k] < D[k]) && (m_bek[k] < BM[k]);
      fire = ereq && hazir[k];
      denetle($sformatf("k%0d istek_gecerli", k), ig[k], ereq);
      if (ereq) denetle($sformatf("k%0d istek_adres", k), iadr[k], m_ps[k]);
      denetle($sformatf("k%0d ps_o", k), pso[k], m_ops[k]);
      denetle($sformatf("k%0d buyruk_o", k), buyo[k], m_obuy[k]);
      denetle($sformatf("k%0d gecerli_o", k), go[k], m_og[k]);
      denetle($sformatf("k%0d doluluk_o", k), (k == 0) ? dol0 : {1'b0, dol1},
              m_q[k].size());
      // cache side
      if (ig[k] && hazir[k]) begin
        c_adr[k].push_back(iadr[k]);
        c_due[k].push_back(cyc + int'($urandom_range(c_lmax, c_lmin)));
      end
      if (yv[k]) begin
        void'(c_adr[k].pop_front());
        void'(c_due[k].pop_front());
      end
      // model: output stage uses queue contents from before this cycle's push
      bek0 = m_bek[k];
      if (yon) begin
        m_og[k] = 1'b0; m_obuy[k] = NOP;
      end else if (!durdur[k]) begin
        if (m_q[k].size() > 0) begin
          c = m_q[k].pop_front();
          m_ops[k] = c[63:32]; m_obuy[k] = c[31:0]; m_og[k] = 1'b1;
        end else begin
          m_og[k] = 1'b0; m_obuy[k] = NOP;
        end
      end
      if (yv[k]) begin
        m_bek[k]--;
        if (yon || m_drop[k] > 0) begin
          if (m_drop[k] > 0) m_drop[k]--;
        end else begin
          tag = (m_tag[k].size() > 0) ? m_tag[k].pop_front() : 32'hDEAD_BEEF;
          m_q[k].push_back({tag, yb[k]});
        end
      end
      if (yon) begin
        m_drop[k] = bek0 - int'(yv[k]);
        m_q[k].delete();
        m_tag[k].delete();
        m_ps[k] = tgt;
      end else if (fire) begin
        m_tag[k].push_back(m_ps[k]);
        m_ps[k] = m_ps[k] + 32'd4;
        m_bek[k]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sur(input logic h, input logic o, input logic [31:0] ha,
                     input logic [31:0] oa, input logic d, input logic hz);
    hata = {2{h}}; ong = {2{o}}; hadr = {2{ha}}; oadr = {2{oa}};
    durdur = {2{d}}; hazir = {2{hz}};
    cevrim();
  endtask

  task automatic calistir(input int n, input int p_haz, input int p_dur,
                          input int p_yon);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 2; k++) begin
        hazir[k]  = ($urandom_range(99) < p_haz);
        durdur[k] = ($urandom_range(99) < p_dur);
        hata[k]   = ($urandom_range(99) < p_yon);
        ong[k]    = ($urandom_range(99) < p_yon);
        hadr[k]   = $urandom & 32'h0000_FFFC;
        oadr[k]   = ($urandom_range(3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_FFFC);
      end
      cevrim();
    end
  endtask

  initial begin
    D[0] = 4; D[1] = 2; BM[0] = 2; BM[1] = 1;
    for (int k = 0; k < 2; k++) begin
      m_ps[k] = 32'h0; m_bek[k] = 0; m_drop[k] = 0;
      m_ops[k] = 32'h0; m_obuy[k] = NOP; m_og[k] = 1'b0;
    end
    durdur = '0; hata = '0; ong = '0; hazir = '0; yv = '0;
    hadr = '0; oadr = '0; yb = '0;
    #12;
    for (int k = 0; k < 2; k++) begin
      denetle($sformatf("k%0d rst istek_gecerli", k), ig[k], 1'b0);
      denetle($sformatf("k%0d rst gecerli_o", k), go[k], 1'b0);
      denetle($sformatf("k%0d rst buyruk_o", k), buyo[k], NOP);
      denetle($sformatf("k%0d rst ps_o", k), pso[k], 32'h0);
      denetle($sformatf("k%0d rst doluluk_o", k), (k == 0) ? dol0 : {1'b0, dol1}, 3'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // streaming with 1-cycle responses
    c_lmin = 1; c_lmax = 1;
    calistir(20, 100, 0, 0);
    // decode stall fills the queue, then drains
    calistir(10, 100, 100, 0);
    calistir(12, 100, 0, 0);
    // redirect with two requests outstanding
    c_lmin = 3; c_lmax = 3;
    sur(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    sur(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    sur(1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b1);
    calistir(15, 100, 0, 0);
    // simultaneous redirects: mispredict wins
    sur(1'b1, 1'b1, 32'h300, 32'h400, 1'b0, 1'b1);
    calistir(15, 100, 0, 0);
    // redirects colliding with responses
    c_lmin = 2; c_lmax = 2;
    calistir(40, 100, 0, 8);
    // long random run
    c_lmin = 1; c_lmax = 5;
    calistir(3000, 70, 30, 3);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
